// File: rtl/rotary_calc.sv
// Rotary-encoder operand entry: CW detents load A/B nibbles then the opcode, CCW steps back.
// ROTARY_CALC_SYNC_EN adds a 2-flop input synchroniser (3-edge step latency instead of 1).
module rotary_calc #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rotation_event,
  input  logic             rotation_direction,
  input  logic [3:0]       Y,
  output logic [WIDTH:0]   led,
  output logic             result_valid,
  output logic [3:0]       stage
);

  localparam int C       = (WIDTH + 3) / 4;
  localparam int CW      = 4 * C;
  localparam int STAGE_W = 4;
  localparam logic [STAGE_W-1:0] OP_STAGE   = STAGE_W'(2 * C);
  localparam logic [STAGE_W-1:0] SHOW_STAGE = STAGE_W'(2 * C + 1);

  logic             ev;
  logic             dir;
  logic             prev_event;
  logic             step;
  logic [WIDTH-1:0] opa, opa_n;
  logic [WIDTH-1:0] opb, opb_n;
  logic [1:0]       opcode, opcode_n;
  logic [STAGE_W-1:0] stage_n;
  logic [WIDTH:0]   led_n;
  logic             valid_n;
  int               sk;

`ifdef ROTARY_CALC_SYNC_EN
  logic [1:0] ev_sync;
  logic [1:0] dir_sync;

  // Event resets high so a level held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_sync  <= 2'b11;
      dir_sync <= 2'b00;
    end else begin
      ev_sync  <= {ev_sync[0], rotation_event};
      dir_sync <= {dir_sync[0], rotation_direction};
    end
  end

  assign ev  = ev_sync[1];
  assign dir = dir_sync[1];
`else
  assign ev  = rotation_event;
  assign dir = rotation_direction;
`endif

  assign step = ev & ~prev_event;

  // Replace nibble k of cur with nib; bits above WIDTH-1 fall away.
  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] cur,
                                                 input int k,
                                                 input logic [3:0] nib);
    logic [CW-1:0] mask;
    logic [CW-1:0] wide;
    mask = CW'(4'hF) << (4 * k);
    wide = {C{nib}};
    return (cur & ~mask[WIDTH-1:0]) | (wide[WIDTH-1:0] & mask[WIDTH-1:0]);
  endfunction

  function automatic logic [WIDTH:0] calc(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [1:0] opc);
    logic [WIDTH:0] ax;
    logic [WIDTH:0] bx;
    logic [WIDTH:0] r;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (opc)
      2'b00:   r = ax + bx;
      2'b01:   r = ax - bx;
      2'b10:   r = ax & bx;
      default: r = ax ^ bx;
    endcase
    return r;
  endfunction

  always_comb begin
    opa_n    = opa;
    opb_n    = opb;
    opcode_n = opcode;
    stage_n  = stage;
    led_n    = led;
    valid_n  = result_valid;
    sk       = int'(stage);
    if (step) begin
      if (dir) begin
        if (sk < C) begin
          opa_n   = put_chunk(opa, sk, Y);
          stage_n = stage + STAGE_W'(1);
        end else if (sk < 2 * C) begin
          opb_n   = put_chunk(opb, sk - C, Y);
          stage_n = stage + STAGE_W'(1);
        end else if (stage == OP_STAGE) begin
          opcode_n = Y[1:0];
          led_n    = calc(opa, opb, opcode_n);
          valid_n  = 1'b1;
          stage_n  = SHOW_STAGE;
        end else begin
          stage_n = '0;
          opa_n   = '0;
          opb_n   = '0;
          valid_n = 1'b0;
        end
      end else if (stage == SHOW_STAGE) begin
        stage_n  = OP_STAGE;
        opcode_n = '0;
        valid_n  = 1'b0;
      end else if (sk != 0) begin
        // Clear the field of the stage being returned to.
        stage_n = stage - STAGE_W'(1);
        if (sk - 1 < C) opa_n = put_chunk(opa, sk - 1, 4'h0);
        else            opb_n = put_chunk(opb, sk - 1 - C, 4'h0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_event   <= 1'b1;
      opa          <= '0;
      opb          <= '0;
      opcode       <= '0;
      stage        <= '0;
      led          <= '0;
      result_valid <= 1'b0;
    end else begin
      prev_event   <= ev;
      opa          <= opa_n;
      opb          <= opb_n;
      opcode       <= opcode_n;
      stage        <= stage_n;
      led          <= led_n;
      result_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_rotary_calc.sv
// Bench for rotary_calc (WIDTH=7): fixed vector table, held-event/reset sequences, random steps vs a model.
module tb_rotary_calc;

  localparam int W = 7;
  localparam int C = (W + 3) / 4;
`ifdef ROTARY_CALC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         ev;
  logic         dir;
  logic [3:0]   y;
  logic [W:0]   led;
  logic         result_valid;
  logic [3:0]   stage;

  int errors;
  int checks;

  // Reference model state: nibble lists for each operand, current stage, shown result.
  int m_stage;
  int m_led;
  bit m_valid;
  int m_a[C];
  int m_b[C];

  typedef struct {
    bit dir;
    int y;
    int st;
    int led;
    bit vld;
  } vec_t;
  vec_t tbl[$];

  rotary_calc #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rotation_event    (ev),
    .rotation_direction(dir),
    .Y                 (y),
    .led               (led),
    .result_valid      (result_valid),
    .stage             (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void add_vec(input bit d, input int yv, input int st, input int l, input bit v);
    vec_t r;
    r.dir = d; r.y = yv; r.st = st; r.led = l; r.vld = v;
    tbl.push_back(r);
  endfunction

  function automatic int operand(input bit is_b);
    int v;
    v = 0;
    for (int k = 0; k < C; k++) v += (is_b ? m_b[k] : m_a[k]) * (1 << (4 * k));
    return v % (1 << W);
  endfunction

  function automatic void model_reset();
    m_stage = 0; m_led = 0; m_valid = 0;
    for (int k = 0; k < C; k++) begin m_a[k] = 0; m_b[k] = 0; end
  endfunction

  function automatic void model_step(input bit d, input int yv);
    int a, b, r;
    if (d) begin
      if (m_stage < C) begin
        m_a[m_stage] = yv; m_stage++;
      end else if (m_stage < 2 * C) begin
        m_b[m_stage - C] = yv; m_stage++;
      end else if (m_stage == 2 * C) begin
        a = operand(0); b = operand(1);
        case (yv % 4)
          0: r = a + b;
          1: r = (a - b + (1 << (W + 1))) % (1 << (W + 1));
          2: r = a & b;
          default: r = a ^ b;
        endcase
        m_led = r; m_valid = 1; m_stage = 2 * C + 1;
      end else begin
        model_reset_entry();
      end
    end else if (m_stage == 2 * C + 1) begin
      m_stage = 2 * C; m_valid = 0;
    end else if (m_stage > 0) begin
      m_stage--;
      if (m_stage < C) m_a[m_stage] = 0;
      else             m_b[m_stage - C] = 0;
    end
  endfunction

  function automatic void model_reset_entry();
    m_stage = 0; m_valid = 0;
    for (int k = 0; k < C; k++) begin m_a[k] = 0; m_b[k] = 0; end
  endfunction

  // One detent: event high for LAT edges (step lands on the last), then low for LAT edges.
  task automatic do_step(input bit d, input int yv);
    @(negedge clk);
    ev = 1'b1; dir = d; y = 4'(yv);
    repeat (LAT) @(posedge clk);
    #1;
    model_step(d, yv);
    ev = 1'b0; dir = 1'($urandom); y = 4'($urandom);
    repeat (LAT) @(posedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_stage"}, int'(stage), m_stage);
    check({tag, "_led"}, int'(led), m_led);
    check({tag, "_valid"}, int'(result_valid), int'(m_valid));
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; ev = 1'b0; dir = 1'b0; y = 4'h0;
    model_reset();

    // CW Y, expected stage / led / valid after the step
    add_vec(1, 4'h5, 1, 'h000, 0); add_vec(1, 4'h3, 2, 'h000, 0);
    add_vec(1, 4'h2, 3, 'h000, 0); add_vec(1, 4'h1, 4, 'h000, 0);
    add_vec(1, 4'h0, 5, 'h047, 1); add_vec(0, 4'h9, 4, 'h047, 0);
    add_vec(1, 4'h0, 5, 'h047, 1); add_vec(1, 4'hA, 0, 'h047, 0);
    add_vec(1, 4'h1, 1, 'h047, 0); add_vec(1, 4'h0, 2, 'h047, 0);
    add_vec(1, 4'h1, 3, 'h047, 0); add_vec(1, 4'h0, 4, 'h047, 0);
    add_vec(1, 4'h3, 5, 'h000, 1); add_vec(1, 4'h6, 0, 'h000, 0);
    add_vec(1, 4'h2, 1, 'h000, 0); add_vec(1, 4'h1, 2, 'h000, 0);
    add_vec(1, 4'h5, 3, 'h000, 0); add_vec(1, 4'h3, 4, 'h000, 0);
    add_vec(1, 4'h1, 5, 'h0DD, 1); add_vec(1, 4'h0, 0, 'h0DD, 0);
    add_vec(1, 4'hF, 1, 'h0DD, 0); add_vec(1, 4'hF, 2, 'h0DD, 0);
    add_vec(1, 4'hF, 3, 'h0DD, 0); add_vec(1, 4'hF, 4, 'h0DD, 0);
    add_vec(1, 4'h0, 5, 'h0FE, 1); add_vec(1, 4'h0, 0, 'h0FE, 0);
    add_vec(0, 4'h7, 0, 'h0FE, 0);
    // Undo with overwrite: A=0x31 (hi nibble redone), B=0x04 (lo nibble redone), add
    add_vec(1, 4'h1, 1, 'h0FE, 0); add_vec(1, 4'h2, 2, 'h0FE, 0);
    add_vec(0, 4'hE, 1, 'h0FE, 0); add_vec(1, 4'h3, 2, 'h0FE, 0);
    add_vec(1, 4'h1, 3, 'h0FE, 0); add_vec(1, 4'h0, 4, 'h0FE, 0);
    add_vec(0, 4'h8, 3, 'h0FE, 0); add_vec(0, 4'h8, 2, 'h0FE, 0);
    add_vec(1, 4'h4, 3, 'h0FE, 0); add_vec(1, 4'h0, 4, 'h0FE, 0);
    add_vec(1, 4'hC, 5, 'h035, 1); add_vec(1, 4'h0, 0, 'h035, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_stage", int'(stage), 0);
    check("reset_led", int'(led), 0);
    check("reset_valid", int'(result_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 1) @(posedge clk);

    foreach (tbl[i]) begin
      do_step(tbl[i].dir, tbl[i].y);
      check($sformatf("vec%0d_stage", i), int'(stage), tbl[i].st);
      check($sformatf("vec%0d_led", i), int'(led), tbl[i].led);
      check($sformatf("vec%0d_valid", i), int'(result_valid), int'(tbl[i].vld));
    end

    // Held event: one step only, landing on the LAT-th edge.
    @(negedge clk);
    ev = 1'b1; dir = 1'b1; y = 4'h6;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("hold_pre_edge", int'(stage), 0);
    @(posedge clk);
    #1;
    check("hold_step", int'(stage), 1);
    model_step(1, 6);
    repeat (20) @(posedge clk);
    #1;
    check("hold_20", int'(stage), 1);
    ev = 1'b0;
    repeat (LAT) @(posedge clk);
    do_step(0, 4'h3);
    check_model("undo_s1");
    do_step(0, 4'h3);
    check_model("undo_s0");

    for (int n = 0; n < 250; n++) begin
      do_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
      check_model($sformatf("rand%0d", n));
    end

    // Reach stage 3 then reset asynchronously between clock edges.
    for (int n = 0; n < 8 && m_stage != 3; n++) begin
      do_step(1, int'($urandom_range(0, 15)));
      check_model($sformatf("to3_%0d", n));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_stage", int'(stage), 0);
    check("async_rst_led", int'(led), 0);
    check("async_rst_valid", int'(result_valid), 0);
    ev = 1'b1; dir = 1'b1; y = 4'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("held_through_reset", int'(stage), 0);
    ev = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    do_step(1, 4'h9);
    check_model("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
